// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch unit and its skid buffer.
package instr_fetch_unit_pkg;

  localparam int WORD_W      = 32;
  localparam int INSTR_BYTES = 4;
  localparam int SKID_DEPTH  = 2;
  localparam int CNT_W       = $clog2(SKID_DEPTH + 1);
  localparam int PTR_W       = $clog2(SKID_DEPTH);

  localparam logic [WORD_W-1:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;
  localparam logic [WORD_W-1:0] ALIGN_MASK        = WORD_W'(INSTR_BYTES - 1);
  localparam logic [CNT_W-1:0]  SKID_FULL         = CNT_W'(SKID_DEPTH);

  typedef enum logic {
    FETCH_RUN  = 1'b0,
    FETCH_HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry skid buffer between the instruction memory response and the queue.
// Flush wins over push and pop; head reads 0 when the buffer is empty.
module fetch_skid_buf
  import instr_fetch_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [WORD_W-1:0] push_data,
  input  logic              pop,
  input  logic              flush,
  output logic [CNT_W-1:0]  count,
  output logic [WORD_W-1:0] head
);

  logic [WORD_W-1:0] entries [SKID_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the data entries are reset too, so head is defined even before the first capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SKID_DEPTH; i++) entries[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Depth is a power of two, so the pointers wrap by plain increment.
      if (push) begin
        entries[wr_ptr] <= push_data;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = (count != '0) ? entries[rd_ptr] : '0;

  // The caller's credit scheme must never push into a full buffer unless it pops too.
  overflow_a: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && count == SKID_FULL));

endmodule

// File: rtl/instr_fetch_unit.sv
// Sequential instruction fetch: issues word reads to a 1-cycle imem, buffers the
// responses in a skid buffer and pushes them to the instruction queue.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [WORD_W-1:0] PC_RESET  = 32'h0000_0000,
  parameter logic [WORD_W-1:0] HALT_WORD = DEFAULT_HALT_WORD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [WORD_W-1:0] redirect_pc,
  output logic              imem_rd_en,
  output logic [WORD_W-1:0] imem_addr,
  input  logic [WORD_W-1:0] imem_rdata,
  input  logic              q_full,
  output logic              q_wr_en,
  output logic [WORD_W-1:0] q_wr_data,
  output logic              halted,
  output logic              fetch_idle
);

  fetch_state_t      state, state_next;
  logic [WORD_W-1:0] pc, pc_next;
  logic              inflight;
  logic [CNT_W-1:0]  skid_count;
  logic [WORD_W-1:0] skid_head;
  logic              pop, capture, issue;
  logic [CNT_W:0]    occupancy, limit;

  assign pop     = (skid_count != '0) && !q_full && !redirect_valid;
  assign capture = inflight && !redirect_valid && (state == FETCH_RUN);

  // Issue only while buffered plus in-flight words still fit after this cycle's pop.
  assign occupancy = {1'b0, skid_count} + {{CNT_W{1'b0}}, inflight};
  assign limit     = (CNT_W + 1)'(SKID_DEPTH) + {{CNT_W{1'b0}}, pop};
  assign issue     = !rst && fetch_en && (state == FETCH_RUN) && !redirect_valid
                     && (occupancy < limit);

  fetch_skid_buf u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (capture),
    .push_data (imem_rdata),
    .pop       (pop),
    .flush     (redirect_valid),
    .count     (skid_count),
    .head      (skid_head)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    if (redirect_valid) begin
      state_next = FETCH_RUN;
      pc_next    = redirect_pc & ~ALIGN_MASK;
    end else begin
      if (capture && imem_rdata == HALT_WORD) state_next = FETCH_HALT;
      if (issue) pc_next = pc + WORD_W'(INSTR_BYTES);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FETCH_RUN;
      pc       <= PC_RESET;
      inflight <= 1'b0;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      inflight <= issue;
    end
  end

  assign imem_rd_en = issue;
  assign imem_addr  = pc;
  assign q_wr_en    = pop;
  assign q_wr_data  = skid_head;
  assign halted     = (state == FETCH_HALT);
  assign fetch_idle = !inflight && (skid_count == '0);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed vector table, hand-written
// halt/redirect/wrap/reset sequences and a randomized phase against a stream model.
module tb_instr_fetch_unit;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  localparam int NV = 18;

  logic        clk = 1'b0;
  logic        rst, fetch_en, redirect_valid, q_full;
  logic [31:0] redirect_pc, imem_addr, imem_rdata, q_wr_data;
  logic        imem_rd_en, q_wr_en, halted, fetch_idle;

  int checks   = 0;
  int failures = 0;

  logic        halt_on = 1'b0;
  logic [31:0] halt_addr = 32'h1;
  logic        sb_on = 1'b0;
  logic [31:0] exp_addr = '0;
  logic [31:0] exp_push_addr = '0;

  typedef struct {
    logic        fe, qf, rv;
    logic [31:0] rpc;
    logic        rd;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] data;
    logic        idle;
  } vec_t;

  vec_t vecs [NV];

  instr_fetch_unit #(.PC_RESET(32'h0), .HALT_WORD(HALT)) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_rd_en     (imem_rd_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .q_full         (q_full),
    .q_wr_en        (q_wr_en),
    .q_wr_data      (q_wr_data),
    .halted         (halted),
    .fetch_idle     (fetch_idle)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (halt_on && a == halt_addr) ? HALT : a + 32'h100;
  endfunction

  // Synchronous imem: data for a read appears one cycle later; junk otherwise.
  always @(posedge clk)
    imem_rdata <= imem_rd_en ? mem_word(imem_addr) : 32'hBAD0_BAD0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic fe, input logic qf, input logic rv,
                              input logic [31:0] rpc, input logic rd,
                              input logic [31:0] addr, input logic wr,
                              input logic [31:0] data, input logic idle);
    vec_t v;
    v.fe = fe; v.qf = qf; v.rv = rv; v.rpc = rpc;
    v.rd = rd; v.addr = addr; v.wr = wr; v.data = data; v.idle = idle;
    return v;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fetch_en = 1'b0;
    q_full = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Stream model for the random phase: issues walk the address space in order and
  // pushes deliver the words of those same addresses in order, never more than 2 ahead.
  always @(negedge clk) begin
    logic [31:0] na, np;
    if (sb_on) begin
      na = exp_addr;
      np = exp_push_addr;
      if (imem_rd_en) begin
        check("rnd_issue_addr", imem_addr, exp_addr);
        na = exp_addr + 32'd4;
      end
      if (q_wr_en) begin
        check("rnd_push_data", q_wr_data, mem_word(exp_push_addr));
        check_bit("rnd_push_while_full", q_full, 1'b0);
        np = exp_push_addr + 32'd4;
      end
      if (!fetch_en) check_bit("rnd_issue_while_disabled", imem_rd_en, 1'b0);
      check_bit("rnd_outstanding_le2", (na - np) <= 32'd8, 1'b1);
      exp_addr      <= na;
      exp_push_addr <= np;
    end
  end

  initial begin
    logic found;
    int   cyc;

    // Stream from reset, q_full burst, then redirect to 0x43 with one word buffered
    // and one in flight.
    vecs[0]  = mk(1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'h00, 1'b0, 32'h000, 1'b1);
    vecs[1]  = mk(1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'h04, 1'b0, 32'h000, 1'b0);
    vecs[2]  = mk(1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'h08, 1'b1, 32'h100, 1'b0);
    vecs[3]  = mk(1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'h0C, 1'b1, 32'h104, 1'b0);
    vecs[4]  = mk(1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'h10, 1'b1, 32'h108, 1'b0);
    for (int i = 5; i <= 10; i++)
      vecs[i] = mk(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h14, 1'b0, 32'h10C, 1'b0);
    vecs[11] = mk(1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'h14, 1'b1, 32'h10C, 1'b0);
    vecs[12] = mk(1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'h18, 1'b1, 32'h110, 1'b0);
    vecs[13] = mk(1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'h1C, 1'b1, 32'h114, 1'b0);
    vecs[14] = mk(1'b1, 1'b0, 1'b1, 32'h43, 1'b0, 32'h20, 1'b0, 32'h118, 1'b0);
    vecs[15] = mk(1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'h40, 1'b0, 32'h000, 1'b1);
    vecs[16] = mk(1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'h44, 1'b0, 32'h000, 1'b0);
    vecs[17] = mk(1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'h48, 1'b1, 32'h140, 1'b0);

    // Outputs while reset is held, with fetch_en already high.
    rst = 1'b1;
    fetch_en = 1'b1;
    q_full = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    @(posedge clk);
    #1;
    check_bit("rst_imem_rd_en", imem_rd_en, 1'b0);
    check_bit("rst_q_wr_en", q_wr_en, 1'b0);
    check("rst_q_wr_data", q_wr_data, 32'h0);
    check("rst_imem_addr", imem_addr, 32'h0);
    check_bit("rst_halted", halted, 1'b0);
    check_bit("rst_fetch_idle", fetch_idle, 1'b1);

    do_reset();
    for (int i = 0; i < NV; i++) begin
      fetch_en       = vecs[i].fe;
      q_full         = vecs[i].qf;
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      @(negedge clk);
      check_bit($sformatf("vec%0d_imem_rd_en", i), imem_rd_en, vecs[i].rd);
      check($sformatf("vec%0d_imem_addr", i), imem_addr, vecs[i].addr);
      check_bit($sformatf("vec%0d_q_wr_en", i), q_wr_en, vecs[i].wr);
      check($sformatf("vec%0d_q_wr_data", i), q_wr_data, vecs[i].data);
      check_bit($sformatf("vec%0d_fetch_idle", i), fetch_idle, vecs[i].idle);
      check_bit($sformatf("vec%0d_halted", i), halted, 1'b0);
      next_cycle();
    end
    redirect_valid = 1'b0;

    // Halt word at 0x10: pushed, then the in-flight 0x14 response is dropped.
    halt_on = 1'b1;
    halt_addr = 32'h10;
    do_reset();
    fetch_en = 1'b1;
    found = 1'b0;
    cyc = 0;
    while (!found && cyc < 20) begin
      @(negedge clk);
      if (halted) found = 1'b1;
      else begin
        next_cycle();
        cyc++;
      end
    end
    check_bit("halt_reached", found, 1'b1);
    check("halt_cycle", cyc, 6);
    check_bit("halt_word_push_en", q_wr_en, 1'b1);
    check("halt_word_push_data", q_wr_data, HALT);
    next_cycle();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_bit($sformatf("halt_no_issue%0d", i), imem_rd_en, 1'b0);
      check_bit($sformatf("halt_no_push%0d", i), q_wr_en, 1'b0);
      next_cycle();
    end
    @(negedge clk);
    check_bit("halt_idle", fetch_idle, 1'b1);
    check_bit("halt_held", halted, 1'b1);
    next_cycle();
    redirect_valid = 1'b1;
    redirect_pc = 32'h80;
    @(negedge clk);
    check_bit("halt_redir_no_issue", imem_rd_en, 1'b0);
    check_bit("halt_redir_no_push", q_wr_en, 1'b0);
    next_cycle();
    redirect_valid = 1'b0;
    @(negedge clk);
    check_bit("resume_halted_clear", halted, 1'b0);
    check_bit("resume_issue", imem_rd_en, 1'b1);
    check("resume_addr", imem_addr, 32'h80);
    next_cycle();
    next_cycle();
    @(negedge clk);
    check_bit("resume_push_en", q_wr_en, 1'b1);
    check("resume_push_data", q_wr_data, 32'h180);
    halt_on = 1'b0;

    // PC wrap from the top of the address space.
    next_cycle();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    next_cycle();
    redirect_valid = 1'b0;
    @(negedge clk);
    check_bit("wrap_issue_top", imem_rd_en, 1'b1);
    check("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
    next_cycle();
    @(negedge clk);
    check_bit("wrap_issue_zero", imem_rd_en, 1'b1);
    check("wrap_addr_zero", imem_addr, 32'h0);
    next_cycle();
    @(negedge clk);
    check_bit("wrap_push_en", q_wr_en, 1'b1);
    check("wrap_push_data", q_wr_data, 32'h0000_00FC);

    // Asynchronous reset between edges with the skid buffer full.
    next_cycle();
    q_full = 1'b1;
    repeat (4) next_cycle();
    q_full = 1'b0;
    #1;
    check_bit("arst_pre_push", q_wr_en, 1'b1);
    check_bit("arst_pre_issue", imem_rd_en, 1'b1);
    check_bit("arst_pre_busy", fetch_idle, 1'b0);
    rst = 1'b1;
    #1;
    check_bit("arst_q_wr_en", q_wr_en, 1'b0);
    check_bit("arst_imem_rd_en", imem_rd_en, 1'b0);
    check("arst_q_wr_data", q_wr_data, 32'h0);
    check_bit("arst_fetch_idle", fetch_idle, 1'b1);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check_bit("arst_restart_issue", imem_rd_en, 1'b1);
    check("arst_restart_addr", imem_addr, 32'h0);
    check_bit("arst_restart_idle", fetch_idle, 1'b1);
    next_cycle();
    next_cycle();
    @(negedge clk);
    check_bit("arst_first_push_en", q_wr_en, 1'b1);
    check("arst_first_push_data", q_wr_data, 32'h100);

    // Randomized fetch_en / q_full against the stream model, then drain.
    do_reset();
    exp_addr = 32'h0;
    exp_push_addr = 32'h0;
    sb_on = 1'b1;
    for (int i = 0; i < 400; i++) begin
      fetch_en = ($urandom_range(9) < 8);
      q_full   = ($urandom_range(9) < 3);
      next_cycle();
    end
    fetch_en = 1'b0;
    q_full = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (fetch_idle) found = 1'b1;
      next_cycle();
    end
    sb_on = 1'b0;
    check_bit("rnd_drained_idle", found, 1'b1);
    check("rnd_all_pushed", exp_push_addr, exp_addr);
    check_bit("rnd_progress", exp_addr >= 32'd400, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
